muldiv_sequencer: RTL

- Iterative multiply/divide controller for the MIPS ALU.
- Latches two operands on a Start request and runs WIDTH shift-add (multiply) or restoring shift-subtract (divide) steps over a 2*WIDTH-bit working register.
- Writes the result into the High/Low result registers and pulses Done.
- Sits beside the combinational ALU and serves the MULT/MULTU/DIV/DIVU instructions.

---
 rtl/muldiv_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer for the MIPS ALU.
// Runs WIDTH shift-add / restoring shift-subtract steps per operation.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] High,
    output logic [WIDTH-1:0] Low,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      LAST   = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_mag;
    logic [2*WIDTH-1:0] r_work;
    logic               r_neg;
    logic               r_rneg;
    logic               r_bz;
    logic [WIDTH-1:0]   r_high;
    logic [WIDTH-1:0]   r_low;
    logic               r_dz;

    logic               w_is_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_dsh;
    logic [WIDTH:0]     w_dsub;
    logic               w_dge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_div = r_op[1];
    assign w_signed = r_op[0];

    // Operand magnitudes; the most negative value maps to itself as unsigned.
    assign w_abs_a = (w_signed && r_a[WIDTH-1]) ? (~r_a + ONE_W) : r_a;
    assign w_abs_b = (w_signed && r_b[WIDTH-1]) ? (~r_b + ONE_W) : r_b;

    // Multiply step: conditional add into upper half, shift right with carry.
    assign w_madd     = {1'b0, r_work[2*WIDTH-1:WIDTH]} + {1'b0, r_mag};
    assign w_mul_next = r_work[0] ? {w_madd, r_work[WIDTH-1:1]}
                                  : {1'b0, r_work[2*WIDTH-1:1]};

    // Divide step: shift left, trial-subtract divisor, restore on borrow.
    assign w_dsh      = r_work[2*WIDTH-1:WIDTH-1];
    assign w_dsub     = w_dsh - {1'b0, r_mag};
    assign w_dge      = (w_dsh >= {1'b0, r_mag});
    assign w_div_next = w_dge ? {w_dsub[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1}
                              : {w_dsh[WIDTH-1:0], r_work[WIDTH-2:0], 1'b0};

    // Sign correction applied in FIX.
    assign w_prod = r_neg ? (~r_work + ONE_2W) : r_work;
    assign w_quo  = r_neg ? (~r_work[WIDTH-1:0] + ONE_W)
                          : r_work[WIDTH-1:0];
    assign w_rem  = r_rneg ? (~r_work[2*WIDTH-1:WIDTH] + ONE_W)
                           : r_work[2*WIDTH-1:WIDTH];

    assign Busy    = (r_state == LOAD) || (r_state == ITER) || (r_state == FIX);
    assign Done    = (r_state == DONE);
    assign High    = r_high;
    assign Low     = r_low;
    assign DivZero = r_dz;

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_next = LOAD;
            LOAD:    w_next = ITER;
            ITER:    if (r_cnt == LAST) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_mag  <= '0;
            r_work <= '0;
            r_neg  <= 1'b0;
            r_rneg <= 1'b0;
            r_bz   <= 1'b0;
            r_high <= '0;
            r_low  <= '0;
            r_dz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_op <= Op;
                        r_a  <= A;
                        r_b  <= B;
                    end
                end
                LOAD: begin
                    r_cnt <= '0;
                    r_bz  <= (r_b == '0);
                    r_neg <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    if (w_is_div) begin
                        r_mag  <= w_abs_b;
                        r_work <= {{WIDTH{1'b0}}, w_abs_a};
                        r_rneg <= w_signed && r_a[WIDTH-1];
                    end else begin
                        r_mag  <= w_abs_a;
                        r_work <= {{WIDTH{1'b0}}, w_abs_b};
                        r_rneg <= 1'b0;
                    end
                end
                ITER: begin
                    r_cnt  <= r_cnt + 1'b1;
                    r_work <= w_is_div ? w_div_next : w_mul_next;
                end
                FIX: begin
                    if (!w_is_div) begin
                        r_high <= w_prod[2*WIDTH-1:WIDTH];
                        r_low  <= w_prod[WIDTH-1:0];
                        r_dz   <= 1'b0;
                    end else if (r_bz) begin
                        r_high <= r_a;
                        r_low  <= '1;
                        r_dz   <= 1'b1;
                    end else begin
                        r_high <= w_rem;
                        r_low  <= w_quo;
                        r_dz   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
